// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer: FSM state encoding,
// acknowledge codes and the default packet header byte.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATAH  = 3'd2,
    DATAL  = 3'd3,
    CSUM   = 3'd4,
    WRITE  = 3'd5,
    REJECT = 3'd6,
    ACK    = 3'd7
  } state_t;

  localparam logic [7:0] ACK_CODE   = 8'h06;
  localparam logic [7:0] NAK_CODE   = 8'h15;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: clr wins over en; expire is a combinational 1-cycle pulse on the
// P_TIMEOUT_CNT-th enabled cycle, no backpressure.
module uart_cmd_timeout #(
  parameter logic [23:0] P_TIMEOUT_CNT = 24'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [23:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 24'd0;
    end else if (en) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  assign expire = en && !clr && (cnt_q == P_TIMEOUT_CNT - 24'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames 5-byte UART packets into 16-bit register writes; REG_WE one cycle after the checksum byte.
// No backpressure on RX; UART_CMD_ACK_EN adds a TX ack byte that waits while UART_TX_BUSY is high.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  P_HEADER      = HEADER_DEF,
  parameter logic [23:0] P_TIMEOUT_CNT = 24'd1000000,
  parameter int unsigned P_ERR_W       = 8
) (
  input  logic               CLK_100M,
  input  logic               SYS_RST,
`ifdef UART_CMD_ACK_EN
  input  logic               UART_TX_BUSY,
  output logic [7:0]         UART_TX_DATA,
  output logic               UART_TX_VLD,
`endif
  input  logic [7:0]         UART_RX_DATA,
  input  logic               UART_RX_DVLD,
  input  logic               UART_RX_ERR,
  output logic               REG_WE,
  output logic [7:0]         REG_ADDR,
  output logic [15:0]        REG_WDATA,
  output logic               CMD_BUSY,
  output logic [P_ERR_W-1:0] ERR_CNT
);

  state_t             state_q, state_d;
  logic [7:0]         addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [7:0]         reg_addr_q, reg_addr_d;
  logic [15:0]        reg_wdata_q, reg_wdata_d;
  logic               reg_we_q, reg_we_d, cmd_busy_q, cmd_busy_d;
  logic [P_ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic               err_inc, tmo_en, tmo_clr, tmo_expire;
  logic [7:0]         csum;
  logic               hdr_seen;
`ifdef UART_CMD_ACK_EN
  logic               ack_ok_q, ack_ok_d, tx_vld_q, tx_vld_d;
  logic [7:0]         tx_data_q, tx_data_d;
`endif

  assign csum     = addr_q + dhi_q + dlo_q;
  assign hdr_seen = UART_RX_DVLD && (UART_RX_DATA == P_HEADER);
  assign tmo_en   = (state_q == ADDR) || (state_q == DATAH) || (state_q == DATAL) || (state_q == CSUM);
  assign tmo_clr  = UART_RX_DVLD || (state_q == IDLE);

  uart_cmd_timeout #(.P_TIMEOUT_CNT(P_TIMEOUT_CNT)) u_timeout (
    .clk    (CLK_100M),
    .rst    (SYS_RST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dhi_d       = dhi_q;
    dlo_d       = dlo_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_inc     = 1'b0;
`ifdef UART_CMD_ACK_EN
    ack_ok_d    = ack_ok_q;
    tx_vld_d    = 1'b0;
    tx_data_d   = tx_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (hdr_seen) state_d = ADDR;
      end
      ADDR, DATAH, DATAL, CSUM: begin
        // An RX error beats a byte arriving in the same cycle; a byte beats the timeout.
        if (UART_RX_ERR) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end else if (UART_RX_DVLD) begin
          case (state_q)
            ADDR:    begin addr_d = UART_RX_DATA; state_d = DATAH; end
            DATAH:   begin dhi_d  = UART_RX_DATA; state_d = DATAL; end
            DATAL:   begin dlo_d  = UART_RX_DATA; state_d = CSUM;  end
            default: begin
              if (UART_RX_DATA == csum) begin
                state_d     = WRITE;
                reg_addr_d  = addr_q;
                reg_wdata_d = {dhi_q, dlo_q};
              end else begin
                state_d = REJECT;
              end
            end
          endcase
        end else if (tmo_expire) begin
          state_d = IDLE;
          err_inc = 1'b1;
        end
      end
      WRITE, REJECT: begin
        err_inc = (state_q == REJECT);
`ifdef UART_CMD_ACK_EN
        ack_ok_d = (state_q == WRITE);
        state_d  = ACK;
`else
        state_d = hdr_seen ? ADDR : IDLE;
`endif
      end
`ifdef UART_CMD_ACK_EN
      ACK: begin
        err_inc = UART_RX_DVLD;
        if (!UART_TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = ack_ok_q ? ACK_CODE : NAK_CODE;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    reg_we_d   = (state_d == WRITE);
    cmd_busy_d = (state_d != IDLE);
    err_cnt_d  = err_cnt_q;
    if (err_inc && (err_cnt_q != {P_ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(P_ERR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK_100M) begin
    if (SYS_RST) begin
      state_q     <= IDLE;
      addr_q      <= 8'd0;
      dhi_q       <= 8'd0;
      dlo_q       <= 8'd0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 16'd0;
      reg_we_q    <= 1'b0;
      cmd_busy_q  <= 1'b0;
      err_cnt_q   <= '0;
`ifdef UART_CMD_ACK_EN
      ack_ok_q    <= 1'b0;
      tx_vld_q    <= 1'b0;
      tx_data_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      cmd_busy_q  <= cmd_busy_d;
      err_cnt_q   <= err_cnt_d;
`ifdef UART_CMD_ACK_EN
      ack_ok_q    <= ack_ok_d;
      tx_vld_q    <= tx_vld_d;
      tx_data_q   <= tx_data_d;
`endif
    end
  end

  assign REG_WE    = reg_we_q;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign CMD_BUSY  = cmd_busy_q;
  assign ERR_CNT   = err_cnt_q;
`ifdef UART_CMD_ACK_EN
  assign UART_TX_VLD  = tx_vld_q;
  assign UART_TX_DATA = tx_data_q;
`endif

endmodule
